// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_pkg
// Purpose  : Shared opcode constants, FSM state type and instruction field
//            positions for the ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_ADD  = 6'd0;
  localparam logic [OPC_W-1:0] OP_SUB  = 6'd1;
  localparam logic [OPC_W-1:0] OP_SHL  = 6'd2;
  localparam logic [OPC_W-1:0] OP_SHR  = 6'd3;
  localparam logic [OPC_W-1:0] OP_MOV  = 6'd4;
  localparam logic [OPC_W-1:0] OP_LDL  = 6'd5;
  localparam logic [OPC_W-1:0] OP_LDH  = 6'd6;
  localparam logic [OPC_W-1:0] OP_MOV2 = 6'd7;
  localparam logic [OPC_W-1:0] OP_EQ   = 6'd8;
  localparam logic [OPC_W-1:0] OP_LT   = 6'd9;
  localparam logic [OPC_W-1:0] OP_GT   = 6'd10;
  localparam logic [OPC_W-1:0] OP_NF1  = 6'd11;
  localparam logic [OPC_W-1:0] OP_AND  = 6'd12;
  localparam logic [OPC_W-1:0] OP_NF1B = 6'd13;
  localparam logic [OPC_W-1:0] OP_JMP  = 6'd14;
  localparam logic [OPC_W-1:0] OP_BRF  = 6'd15;

  // Instruction word field positions (imm16 overlaps rb)
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RA_HI  = 20;
  localparam int RA_LO  = 16;
  localparam int RB_HI  = 15;
  localparam int RB_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

endpackage : alu_sequencer_pkg
`default_nettype wire

// File: rtl/alu_seq_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_decode
// Purpose  : Combinational opcode classification for the ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_decode
  import alu_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output logic             writes_rd_o,
  output logic             is_compare_o,
  output logic             is_branch_o,
  output logic             is_illegal_o
);

  // Opcode ranges: 0-7 write rd, 8-13 update flags, 14/15 branch, >15 illegal
  always_comb begin
    writes_rd_o  = (opcode_i <= OP_MOV2);
    is_compare_o = (opcode_i >= OP_EQ) && (opcode_i <= OP_NF1B);
    is_branch_o  = (opcode_i == OP_JMP) || (opcode_i == OP_BRF);
    is_illegal_o = (opcode_i > OP_BRF);
  end

endmodule : alu_seq_decode
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-cycle controller that fetches operands from the register
//            file, strobes the ALU for one cycle and retires the result to
//            the register file, the flags or the program counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 REG_AW   = 5,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_word,
  output logic [DATA_W-1:0] pc,
  output logic [REG_AW-1:0] rf_ra_addr,
  output logic [REG_AW-1:0] rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [5:0]        alu_instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_reg8,
  output logic [15:0]       alu_value,
  output logic              alu_highlow,
  output logic              alu_f1,
  output logic              alu_f2,
  output logic              alu_strobe,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_f3,
  output logic              flag,
  output logic              illegal,
  output logic              busy
);

  state_e              state_q;
  logic [DATA_W-1:0]   pc_q;
  logic [DATA_W-1:0]   pc_d;
  logic                f1_q;
  logic                f2_q;
  logic                illegal_q;

  // Latched instruction fields (ra/rb are consumed at accept time)
  logic [OPC_W-1:0]    opcode_q;
  logic [4:0]          rd_q;
  logic [15:0]         imm_q;

  // Registered outputs
  logic [REG_AW-1:0]   rf_ra_addr_q;
  logic [REG_AW-1:0]   rf_rb_addr_q;
  logic                rf_we_q;
  logic [REG_AW-1:0]   rf_wa_q;
  logic [DATA_W-1:0]   rf_wd_q;
  logic [OPC_W-1:0]    alu_instr_q;
  logic [DATA_W-1:0]   opa_q;
  logic [DATA_W-1:0]   opb_q;
  logic [15:0]         alu_value_q;
  logic                alu_highlow_q;
  logic                alu_strobe_q;

  logic                dec_writes_rd;
  logic                dec_is_compare;
  logic                dec_is_branch;
  logic                dec_is_illegal;

  alu_seq_decode u_decode (
    .opcode_i     (opcode_q),
    .writes_rd_o  (dec_writes_rd),
    .is_compare_o (dec_is_compare),
    .is_branch_o  (dec_is_branch),
    .is_illegal_o (dec_is_illegal)
  );

  // Next PC: taken branch loads operand A (BRF uses F1 from before this
  // instruction), everything else advances by one with natural wrap
  always_comb begin
    pc_d = pc_q + DATA_W'(1);
    if ((state_q == EXEC) && dec_is_branch && ((opcode_q == OP_JMP) || f1_q)) begin
      pc_d = opa_q;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      f1_q          <= 1'b0;
      f2_q          <= 1'b0;
      illegal_q     <= 1'b0;
      opcode_q      <= '0;
      rd_q          <= '0;
      imm_q         <= '0;
      rf_ra_addr_q  <= '0;
      rf_rb_addr_q  <= '0;
      rf_we_q       <= 1'b0;
      rf_wa_q       <= '0;
      rf_wd_q       <= '0;
      alu_instr_q   <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      alu_value_q   <= '0;
      alu_highlow_q <= 1'b0;
      alu_strobe_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            opcode_q     <= instr_word[OPC_HI:OPC_LO];
            rd_q         <= instr_word[RD_HI:RD_LO];
            imm_q        <= instr_word[IMM_HI:IMM_LO];
            rf_ra_addr_q <= REG_AW'(instr_word[RA_HI:RA_LO]);
            rf_rb_addr_q <= REG_AW'(instr_word[RB_HI:RB_LO]);
            state_q      <= READ;
          end
        end
        READ: begin
          if (dec_is_illegal) begin
            illegal_q <= 1'b1;
            pc_q      <= pc_d;
            state_q   <= IDLE;
          end else begin
            opa_q         <= rf_ra_data;
            opb_q         <= rf_rb_data;
            alu_instr_q   <= opcode_q;
            alu_value_q   <= imm_q;
            alu_highlow_q <= (opcode_q == OP_LDH);
            alu_strobe_q  <= 1'b1;
            state_q       <= EXEC;
          end
        end
        EXEC: begin
          alu_strobe_q  <= 1'b0;
          alu_instr_q   <= '0;
          opa_q         <= '0;
          opb_q         <= '0;
          alu_value_q   <= '0;
          alu_highlow_q <= 1'b0;
          pc_q          <= pc_d;
          if (dec_writes_rd) begin
            rf_we_q <= (rd_q != 5'd0);
            rf_wa_q <= REG_AW'(rd_q);
            rf_wd_q <= alu_c;
            state_q <= WB;
          end else begin
            if (dec_is_compare) begin
              f2_q <= f1_q;
              f1_q <= alu_f3;
            end
            state_q <= IDLE;
          end
        end
        WB: begin
          rf_we_q <= 1'b0;
          rf_wa_q <= '0;
          rf_wd_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign pc          = pc_q;
  assign rf_ra_addr  = rf_ra_addr_q;
  assign rf_rb_addr  = rf_rb_addr_q;
  assign rf_we       = rf_we_q;
  assign rf_wa       = rf_wa_q;
  assign rf_wd       = rf_wd_q;
  assign alu_instr   = alu_instr_q;
  assign alu_a       = opa_q;
  assign alu_b       = opb_q;
  assign alu_reg8    = opa_q;
  assign alu_value   = alu_value_q;
  assign alu_highlow = alu_highlow_q;
  assign alu_strobe  = alu_strobe_q;
  assign alu_f1      = f1_q;
  assign alu_f2      = f2_q;
  assign flag        = f1_q;
  assign illegal     = illegal_q;

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer with a register-file and
//            ALU behavioural model and a write-back scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [31:0] pc;
  logic [4:0]  rf_ra_addr;
  logic [4:0]  rf_rb_addr;
  logic [31:0] rf_ra_data;
  logic [31:0] rf_rb_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [5:0]  alu_instr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_reg8;
  logic [15:0] alu_value;
  logic        alu_highlow;
  logic        alu_f1;
  logic        alu_f2;
  logic        alu_strobe;
  logic [31:0] alu_c;
  logic        alu_f3;
  logic        flag;
  logic        illegal;
  logic        busy;

  alu_sequencer #(.DATA_W(32), .REG_AW(5), .RESET_PC(32'h0)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_word  (instr_word),
    .pc          (pc),
    .rf_ra_addr  (rf_ra_addr),
    .rf_rb_addr  (rf_rb_addr),
    .rf_ra_data  (rf_ra_data),
    .rf_rb_data  (rf_rb_data),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .alu_instr   (alu_instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_reg8    (alu_reg8),
    .alu_value   (alu_value),
    .alu_highlow (alu_highlow),
    .alu_f1      (alu_f1),
    .alu_f2      (alu_f2),
    .alu_strobe  (alu_strobe),
    .alu_c       (alu_c),
    .alu_f3      (alu_f3),
    .flag        (flag),
    .illegal     (illegal),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file contents driven straight onto the read ports
  logic [31:0] rf [32];
  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];

  // Simple ALU model
  always_comb begin
    alu_c  = '0;
    alu_f3 = 1'b0;
    case (alu_instr)
      6'd0:  alu_c = alu_a + alu_b;
      6'd1:  alu_c = alu_a - alu_b;
      6'd2:  alu_c = alu_a << alu_b[4:0];
      6'd3:  alu_c = alu_a >> alu_b[4:0];
      6'd4:  alu_c = alu_a;
      6'd5:  alu_c = {16'h0000, alu_value};
      6'd6:  alu_c = {alu_value, 16'h0000};
      6'd7:  alu_c = alu_b;
      6'd8:  alu_f3 = (alu_a == alu_b);
      6'd9:  alu_f3 = (alu_a < alu_b);
      6'd10: alu_f3 = (alu_a > alu_b);
      default: ;
    endcase
  end

  int total = 0;
  int bad   = 0;
  int strobe_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wb_t;
  wb_t sbq[$];

  task automatic push_wb(input logic [4:0] wa, input logic [31:0] wd);
    wb_t e;
    e.wa = wa;
    e.wd = wd;
    sbq.push_back(e);
  endtask

  // Scoreboard: every write-back pulse must match the oldest expectation
  always @(negedge clock) begin
    if (!reset && rf_we) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: rf_wa=%0d rf_wd=%h, expected no write", rf_wa, rf_wd);
      end else begin
        wb_t e;
        e = sbq.pop_front();
        chk("wb_addr", {27'h0, rf_wa}, {27'h0, e.wa});
        chk("wb_data", rf_wd, e.wd);
      end
    end
  end

  always @(negedge clock) begin
    if (alu_strobe) strobe_n++;
  end

  function automatic logic [31:0] mkw(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] ra, input logic [15:0] imm);
    return {op, rd, ra, imm};
  endfunction

  // Offer one instruction in IDLE; returns at the negedge of the READ cycle
  task automatic send(input logic [31:0] w);
    int n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", {31'h0, instr_ready}, 32'h1);
    instr_word  = w;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    instr_word  = $urandom;
  endtask

  // Count cycles from accept until instr_ready returns (bounded)
  task automatic wait_idle(input int start, output int cyc);
    cyc = start;
    while (!instr_ready && cyc < 30) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [15:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[8];

  initial begin : g_global_timeout
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : g_main
    int cyc;
    int s0;
    logic [31:0] exp_pc;
    logic [4:0]  rb;

    vt[0] = '{6'd0, 5'd1,  5'd2,  16'h1800, 32'd5,          32'd7,  32'd12};
    vt[1] = '{6'd1, 5'd4,  5'd5,  16'h3000, 32'd20,         32'd25, 32'hFFFF_FFFB};
    vt[2] = '{6'd2, 5'd7,  5'd8,  16'h4800, 32'd3,          32'd4,  32'h0000_0030};
    vt[3] = '{6'd3, 5'd10, 5'd11, 16'h6000, 32'h8000_0000,  32'd31, 32'h0000_0001};
    vt[4] = '{6'd4, 5'd13, 5'd14, 16'h7800, 32'hDEAD_BEEF,  32'd1,  32'hDEAD_BEEF};
    vt[5] = '{6'd5, 5'd16, 5'd17, 16'h1234, 32'h1111_1111,  32'h2,  32'h0000_1234};
    vt[6] = '{6'd6, 5'd5,  5'd1,  16'hABCD, 32'h3333_3333,  32'h4,  32'hABCD_0000};
    vt[7] = '{6'd7, 5'd0,  5'd2,  16'h1800, 32'd1,          32'h55, 32'h0000_0055};

    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_word  = '0;
    repeat (2) @(negedge clock);

    chk("rst_pc",      pc, 32'h0);
    chk("rst_ready",   {31'h0, instr_ready}, 32'h1);
    chk("rst_busy",    {31'h0, busy}, 32'h0);
    chk("rst_illegal", {31'h0, illegal}, 32'h0);
    chk("rst_flag",    {31'h0, flag}, 32'h0);
    chk("rst_rf_we",   {31'h0, rf_we}, 32'h0);
    chk("rst_strobe",  {31'h0, alu_strobe}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    exp_pc = 32'h0;

    // Write-back ops from the vector table
    for (int i = 0; i < 8; i++) begin
      rb = vt[i].imm[15:11];
      rf[vt[i].ra] = vt[i].a;
      rf[rb]       = vt[i].b;
      if (vt[i].rd != 5'd0) push_wb(vt[i].rd, vt[i].exp);
      send(mkw(vt[i].op, vt[i].rd, vt[i].ra, vt[i].imm));
      chk("read_no_strobe", {31'h0, alu_strobe}, 32'h0);
      @(negedge clock);
      chk("exec_strobe",   {31'h0, alu_strobe}, 32'h1);
      chk("exec_op",       {26'h0, alu_instr}, {26'h0, vt[i].op});
      chk("exec_a",        alu_a, vt[i].a);
      chk("exec_b",        alu_b, vt[i].b);
      chk("exec_reg8",     alu_reg8, vt[i].a);
      chk("exec_value",    {16'h0, alu_value}, {16'h0, vt[i].imm});
      chk("exec_highlow",  {31'h0, alu_highlow}, (vt[i].op == 6'd6) ? 32'h1 : 32'h0);
      wait_idle(2, cyc);
      chk("wb_cycles", cyc, 4);
      exp_pc = exp_pc + 1;
      chk("wb_pc", pc, exp_pc);
      chk("wb_sb_empty", sbq.size(), 0);
      chk("wb_strobe_off", {31'h0, alu_strobe}, 32'h0);
    end

    // Compare sets F1, then BRF taken
    rf[2] = 32'd9;
    rf[3] = 32'd9;
    send(mkw(6'd8, 5'd0, 5'd2, 16'h1800));
    wait_idle(1, cyc);
    chk("cmp_cycles", cyc, 3);
    chk("cmp_flag_set", {31'h0, flag}, 32'h1);
    exp_pc = exp_pc + 1;
    chk("cmp_pc", pc, exp_pc);

    rf[4] = 32'h100;
    send(mkw(6'd15, 5'd0, 5'd4, 16'h0000));
    @(negedge clock);
    chk("brf_alu_f1", {31'h0, alu_f1}, 32'h1);
    wait_idle(2, cyc);
    chk("brf_cycles", cyc, 3);
    exp_pc = 32'h100;
    chk("brf_taken_pc", pc, exp_pc);

    // Compare clears F1 (F2 gets old F1), BRF falls through
    rf[3] = 32'd8;
    send(mkw(6'd8, 5'd0, 5'd2, 16'h1800));
    wait_idle(1, cyc);
    chk("cmp2_flag_clr", {31'h0, flag}, 32'h0);
    chk("cmp2_f2",       {31'h0, alu_f2}, 32'h1);
    exp_pc = exp_pc + 1;
    send(mkw(6'd15, 5'd0, 5'd4, 16'h0000));
    wait_idle(1, cyc);
    exp_pc = exp_pc + 1;
    chk("brf_nt_pc", pc, exp_pc);

    // Unconditional jump
    rf[6] = 32'h40;
    send(mkw(6'd14, 5'd0, 5'd6, 16'h0000));
    wait_idle(1, cyc);
    exp_pc = 32'h40;
    chk("jmp_pc", pc, exp_pc);

    // Illegal opcode: no strobe, 2-cycle turnaround, sticky flag
    s0 = strobe_n;
    send(mkw(6'h20, 5'd1, 5'd2, 16'h1800));
    wait_idle(1, cyc);
    chk("ill_cycles", cyc, 2);
    chk("ill_flag",   {31'h0, illegal}, 32'h1);
    chk("ill_no_strobe", strobe_n, s0);
    exp_pc = exp_pc + 1;
    chk("ill_pc", pc, exp_pc);

    rf[2] = 32'd100;
    rf[3] = 32'd1;
    push_wb(5'd9, 32'd101);
    send(mkw(6'd0, 5'd9, 5'd2, 16'h1800));
    wait_idle(1, cyc);
    chk("post_ill_cycles", cyc, 4);
    chk("ill_sticky", {31'h0, illegal}, 32'h1);
    chk("post_ill_sb", sbq.size(), 0);
    exp_pc = exp_pc + 1;
    chk("post_ill_pc", pc, exp_pc);

    // Set F1 again so the reset clearing it is visible
    rf[3] = 32'd100;
    send(mkw(6'd8, 5'd0, 5'd2, 16'h1800));
    wait_idle(1, cyc);
    chk("pre_rst_flag", {31'h0, flag}, 32'h1);

    // Reset during EXEC drops the instruction
    send(mkw(6'd0, 5'd1, 5'd2, 16'h1800));
    @(negedge clock);
    chk("pre_rst_strobe", {31'h0, alu_strobe}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_pc",     pc, 32'h0);
    chk("mid_rst_ready",  {31'h0, instr_ready}, 32'h1);
    chk("mid_rst_busy",   {31'h0, busy}, 32'h0);
    chk("mid_rst_flag",   {31'h0, flag}, 32'h0);
    chk("mid_rst_f2",     {31'h0, alu_f2}, 32'h0);
    chk("mid_rst_strobe", {31'h0, alu_strobe}, 32'h0);
    chk("mid_rst_ill",    {31'h0, illegal}, 32'h0);
    @(negedge clock);
    reset       = 1'b0;
    rf[3]       = 32'd23;
    instr_word  = mkw(6'd0, 5'd11, 5'd2, 16'h1800);
    instr_valid = 1'b1;
    push_wb(5'd11, 32'd123);
    @(negedge clock);
    instr_valid = 1'b0;
    chk("post_rst_accept", {31'h0, busy}, 32'h1);
    wait_idle(1, cyc);
    chk("post_rst_cycles", cyc, 4);
    chk("post_rst_pc", pc, 32'h1);
    chk("post_rst_sb", sbq.size(), 0);

    repeat (3) @(negedge clock);
    chk("final_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_sequencer
`default_nettype wire
